// File: rtl/ccc_dyncfg_sequencer.sv
// CCC/PLL power-up and reconfiguration sequencer: writes and verifies a CCC
// register table over APB, releases the PLL, qualifies LOCK, then releases fabric reset.
module ccc_dyncfg_sequencer #(
    parameter int unsigned              NUM_REGS     = 4,
    parameter logic [NUM_REGS*14-1:0]   CFG_TABLE    = '0,
    parameter int unsigned              ARST_CYCLES  = 16,
    parameter int unsigned              LOCK_STABLE  = 1024,
    parameter int unsigned              LOCK_TIMEOUT = 65535,
    parameter int unsigned              MAX_RETRY    = 3,
    parameter bit                       AUTO_START   = 1'b1
) (
    input  logic       PCLK,
    input  logic       PRESET_N,
    input  logic       START,
    input  logic       CCC_BUSY,
    input  logic [7:0] CCC_PRDATA,
    input  logic       PLL_LOCK,
    output logic       CCC_PSEL,
    output logic       CCC_PENABLE,
    output logic       CCC_PWRITE,
    output logic [5:0] CCC_PADDR,
    output logic [7:0] CCC_PWDATA,
    output logic       PLL_ARST_N,
    output logic       PLL_POWERDOWN_N,
    output logic       SYS_RESET_N,
    output logic       CFG_DONE,
    output logic       CFG_ERROR,
    output logic [1:0] ERR_CODE
);

    localparam int unsigned IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned AW = (ARST_CYCLES > 0) ? $clog2(ARST_CYCLES + 1) : 1;
    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_REGS - 1);
    localparam logic [AW-1:0] ARST_LAST  = AW'(ARST_CYCLES - 1);
    localparam logic [AW-1:0] ARST_MAX   = AW'(ARST_CYCLES);
    localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PLL_RST,
        ST_WR_SETUP,
        ST_WR_ACCESS,
        ST_RD_SETUP,
        ST_RD_ACCESS,
        ST_REL_RST,
        ST_WAIT_LOCK,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] stable_q, stable_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [1:0]    err_q, err_d;
    logic          auto_q, auto_d;
    logic          lock_ff1_q, lock_s_q;
    logic          retry_req;

    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          pwrite_q, pwrite_d;
    logic [5:0]    paddr_q, paddr_d;
    logic [7:0]    pwdata_q, pwdata_d;
    logic          arst_n_q, arst_n_d;
    logic          pd_n_q, pd_n_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;

    logic [5:0]    tab_addr [NUM_REGS];
    logic [7:0]    tab_data [NUM_REGS];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            tab_addr[i] = CFG_TABLE[i*14+8 +: 6];
            tab_data[i] = CFG_TABLE[i*14   +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = '0;
        stable_d  = '0;
        tmo_d     = '0;
        retry_d   = retry_q;
        err_d     = err_q;
        auto_d    = auto_q;
        retry_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START || auto_q) begin
                    auto_d  = 1'b0;
                    retry_d = '0;
                    err_d   = 2'd0;
                    state_d = ST_PLL_RST;
                end
            end
            ST_PLL_RST: begin
                idx_d = '0;
                cnt_d = (cnt_q == ARST_MAX) ? cnt_q : cnt_q + AW'(1);
                if (cnt_q >= ARST_LAST && !CCC_BUSY) state_d = ST_WR_SETUP;
            end
            ST_WR_SETUP: state_d = ST_WR_ACCESS;
            ST_WR_ACCESS: begin
                if (!CCC_BUSY) state_d = ST_RD_SETUP;
            end
            ST_RD_SETUP: state_d = ST_RD_ACCESS;
            ST_RD_ACCESS: begin
                // penable_q marks the real access cycle; later cycles here are busy waits
                if (penable_q && CCC_PRDATA != tab_data[idx_q]) begin
                    err_d     = 2'd1;
                    retry_req = 1'b1;
                end else if (idx_q == IDX_LAST) begin
                    state_d = ST_REL_RST;
                end else if (!CCC_BUSY) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_WR_SETUP;
                end
            end
            ST_REL_RST: state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_s_q)
                    stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
                tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);
                if (stable_d == STABLE_MAX) begin
                    state_d = ST_RUN;
                end else if (tmo_d == TMO_MAX) begin
                    err_d     = 2'd2;
                    retry_req = 1'b1;
                end
            end
            ST_RUN: begin
                if (START) begin
                    retry_d = '0;
                    err_d   = 2'd0;
                    state_d = ST_PLL_RST;
                end else if (!lock_s_q) begin
                    err_d   = 2'd3;
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_FAIL: begin
                if (START) begin
                    retry_d = '0;
                    err_d   = 2'd0;
                    state_d = ST_PLL_RST;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (retry_req) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + RW'(1);
                state_d = ST_PLL_RST;
            end else begin
                state_d = ST_FAIL;
            end
        end
    end

    // Outputs are decoded from the next state so they register together with it
    always_comb begin
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        arst_n_d    = 1'b0;
        pd_n_d      = 1'b1;
        sys_rst_n_d = 1'b0;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        case (state_d)
            ST_WR_SETUP: begin
                psel_d   = 1'b1;
                pwrite_d = 1'b1;
                paddr_d  = tab_addr[idx_d];
                pwdata_d = tab_data[idx_d];
            end
            ST_WR_ACCESS: begin
                psel_d    = (state_q != ST_WR_ACCESS);
                penable_d = (state_q != ST_WR_ACCESS);
            end
            ST_RD_SETUP: begin
                psel_d   = 1'b1;
                pwrite_d = 1'b0;
                paddr_d  = tab_addr[idx_d];
            end
            ST_RD_ACCESS: begin
                psel_d    = (state_q != ST_RD_ACCESS);
                penable_d = (state_q != ST_RD_ACCESS);
            end
            ST_REL_RST, ST_WAIT_LOCK: arst_n_d = 1'b1;
            ST_RUN: begin
                arst_n_d    = 1'b1;
                sys_rst_n_d = 1'b1;
                done_d      = 1'b1;
            end
            ST_FAIL: begin
                pd_n_d    = 1'b0;
                cfg_err_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET_N) begin
        if (!PRESET_N) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            stable_q    <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            err_q       <= 2'd0;
            auto_q      <= AUTO_START;
            lock_ff1_q  <= 1'b0;
            lock_s_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            arst_n_q    <= 1'b0;
            pd_n_q      <= 1'b1;
            sys_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            auto_q      <= auto_d;
            lock_ff1_q  <= PLL_LOCK;
            lock_s_q    <= lock_ff1_q;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            arst_n_q    <= arst_n_d;
            pd_n_q      <= pd_n_d;
            sys_rst_n_q <= sys_rst_n_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign CCC_PSEL        = psel_q;
    assign CCC_PENABLE     = penable_q;
    assign CCC_PWRITE      = pwrite_q;
    assign CCC_PADDR       = paddr_q;
    assign CCC_PWDATA      = pwdata_q;
    assign PLL_ARST_N      = arst_n_q;
    assign PLL_POWERDOWN_N = pd_n_q;
    assign SYS_RESET_N     = sys_rst_n_q;
    assign CFG_DONE        = done_q;
    assign CFG_ERROR       = cfg_err_q;
    assign ERR_CODE        = err_q;

endmodule
